// File: rtl/br_ctrl_seq.sv
// Branch/condition-code control sequencer: issues LD_BEN/LD_CC/LD_PC strobes per
// decoded instruction, handshakes via Start/Busy/Done and counts branch outcomes.
module br_ctrl_seq #(
    parameter int CNT_WIDTH = 16,
    parameter bit SATURATE  = 1'b1
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 Start,
    input  logic [3:0]           Opcode,
    input  logic                 BEN_In,
    input  logic                 Clear_Stats,
    output logic                 LD_BEN,
    output logic                 LD_CC,
    output logic                 LD_REG,
    output logic                 LD_PC,
    output logic [1:0]           PCMUX_Sel,
    output logic                 Busy,
    output logic                 Done,
    output logic [CNT_WIDTH-1:0] Taken_Count,
    output logic [CNT_WIDTH-1:0] NotTaken_Count
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        DECODE  = 3'd1,
        BR_EVAL = 3'd2,
        BR_TAKE = 3'd3,
        CC_WB   = 3'd4,
        FINISH  = 3'd5
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_t               state_q, state_d;
    logic [3:0]           opcode_q, opcode_d;
    logic [CNT_WIDTH-1:0] taken_q, taken_d;
    logic [CNT_WIDTH-1:0] ntaken_q, ntaken_d;
    logic                 is_cc_op;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q  <= IDLE;
            opcode_q <= 4'b0000;
            taken_q  <= '0;
            ntaken_q <= '0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
            taken_q  <= taken_d;
            ntaken_q <= ntaken_d;
        end
    end

    // ADD, AND, NOT, LD, LDR, LDI all write a register and set NZP
    always_comb begin
        case (opcode_q)
            4'b0001, 4'b0101, 4'b1001,
            4'b0010, 4'b0110, 4'b1010: is_cc_op = 1'b1;
            default:                   is_cc_op = 1'b0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        opcode_d = opcode_q;
        case (state_q)
            IDLE: begin
                if (Start) begin
                    opcode_d = Opcode;
                    state_d  = DECODE;
                end
            end
            DECODE: begin
                if (opcode_q == 4'b0000) state_d = BR_EVAL;
                else if (is_cc_op)       state_d = CC_WB;
                else                     state_d = FINISH;
            end
            BR_EVAL: state_d = BEN_In ? BR_TAKE : FINISH;
            BR_TAKE: state_d = FINISH;
            CC_WB:   state_d = FINISH;
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        LD_BEN    = 1'b0;
        LD_CC     = 1'b0;
        LD_REG    = 1'b0;
        LD_PC     = 1'b0;
        PCMUX_Sel = 2'b00;
        Done      = 1'b0;
        Busy      = (state_q != IDLE);
        case (state_q)
            DECODE:  LD_BEN = 1'b1;
            BR_TAKE: begin
                LD_PC     = 1'b1;
                PCMUX_Sel = 2'b10;
            end
            CC_WB: begin
                LD_CC  = 1'b1;
                LD_REG = 1'b1;
            end
            FINISH:  Done = 1'b1;
            default: ;
        endcase
    end

    // Clear has priority over a same-cycle branch outcome
    always_comb begin
        taken_d  = taken_q;
        ntaken_d = ntaken_q;
        if (Clear_Stats) begin
            taken_d  = '0;
            ntaken_d = '0;
        end else if (state_q == BR_EVAL) begin
            if (BEN_In) begin
                if (!(SATURATE && (&taken_q))) taken_d = taken_q + CNT_ONE;
            end else begin
                if (!(SATURATE && (&ntaken_q))) ntaken_d = ntaken_q + CNT_ONE;
            end
        end
    end

    assign Taken_Count    = taken_q;
    assign NotTaken_Count = ntaken_q;

endmodule

// File: tb/tb_br_ctrl_seq.sv
// Directed bench for br_ctrl_seq: per-cycle vector table plus hand sequences for
// busy-ignore, counter saturation/wrap (two instances) and stats clear.
module tb_br_ctrl_seq;

    logic       Clk = 1'b0;
    logic       Reset, Start, BEN_In, Clear_Stats;
    logic [3:0] Opcode;
    logic       a_ld_ben, a_ld_cc, a_ld_reg, a_ld_pc, a_busy, a_done;
    logic [1:0] a_pcmux;
    logic [3:0] a_taken, a_ntaken;
    logic       b_ld_ben, b_ld_cc, b_ld_reg, b_ld_pc, b_busy, b_done;
    logic [1:0] b_pcmux;
    logic [3:0] b_taken, b_ntaken;

    int errors = 0;
    int checks = 0;

    always #5 Clk = ~Clk;

    br_ctrl_seq #(.CNT_WIDTH(4), .SATURATE(1'b1)) dut_sat (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Opcode(Opcode), .BEN_In(BEN_In),
        .Clear_Stats(Clear_Stats), .LD_BEN(a_ld_ben), .LD_CC(a_ld_cc), .LD_REG(a_ld_reg),
        .LD_PC(a_ld_pc), .PCMUX_Sel(a_pcmux), .Busy(a_busy), .Done(a_done),
        .Taken_Count(a_taken), .NotTaken_Count(a_ntaken)
    );

    br_ctrl_seq #(.CNT_WIDTH(4), .SATURATE(1'b0)) dut_wrap (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Opcode(Opcode), .BEN_In(BEN_In),
        .Clear_Stats(Clear_Stats), .LD_BEN(b_ld_ben), .LD_CC(b_ld_cc), .LD_REG(b_ld_reg),
        .LD_PC(b_ld_pc), .PCMUX_Sel(b_pcmux), .Busy(b_busy), .Done(b_done),
        .Taken_Count(b_taken), .NotTaken_Count(b_ntaken)
    );

    typedef struct {
        logic       rst, start, ben, clr;
        logic [3:0] op;
        logic       ld_ben, ld_cc, ld_reg, ld_pc;
        logic [1:0] pcmux;
        logic       busy, done;
        logic [3:0] taken, ntaken;
    } vec_t;

    vec_t vq[$];

    task automatic check(input string name, input int step, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %0d expected %0d", name, step, act, exp);
        end
    endtask

    // inputs applied before the edge; outputs expected just after it
    task automatic add(input logic rst, start, input logic [3:0] op, input logic ben, clr,
                       input logic ld_ben, ld_cc, ld_reg, ld_pc, input logic [1:0] pcmux,
                       input logic busy, done, input logic [3:0] taken, ntaken);
        vec_t v;
        v.rst = rst; v.start = start; v.op = op; v.ben = ben; v.clr = clr;
        v.ld_ben = ld_ben; v.ld_cc = ld_cc; v.ld_reg = ld_reg; v.ld_pc = ld_pc;
        v.pcmux = pcmux; v.busy = busy; v.done = done; v.taken = taken; v.ntaken = ntaken;
        vq.push_back(v);
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    int dones;

    initial begin
        Reset = 1'b1; Start = 1'b0; Opcode = 4'h0; BEN_In = 1'b0; Clear_Stats = 1'b0;

        //   rst st op    ben clr  bn cc rg pc mux   by dn tk nt
        add(1, 0, 4'h0, 0, 0,   0, 0, 0, 0, 2'b00, 0, 0, 0, 0); // reset -> IDLE
        add(0, 1, 4'h0, 1, 0,   1, 0, 0, 0, 2'b00, 1, 0, 0, 0); // BR taken: DECODE@1
        add(0, 0, 4'h0, 1, 0,   0, 0, 0, 0, 2'b00, 1, 0, 0, 0); // BR_EVAL@2
        add(0, 0, 4'h0, 1, 0,   0, 0, 0, 1, 2'b10, 1, 0, 1, 0); // BR_TAKE@3
        add(0, 0, 4'h0, 0, 0,   0, 0, 0, 0, 2'b00, 1, 1, 1, 0); // FINISH@4
        add(0, 0, 4'h0, 0, 0,   0, 0, 0, 0, 2'b00, 0, 0, 1, 0); // IDLE
        add(0, 1, 4'h0, 0, 0,   1, 0, 0, 0, 2'b00, 1, 0, 1, 0); // BR not taken
        add(0, 0, 4'h0, 0, 0,   0, 0, 0, 0, 2'b00, 1, 0, 1, 0);
        add(0, 0, 4'h0, 0, 0,   0, 0, 0, 0, 2'b00, 1, 1, 1, 1); // FINISH@3
        add(0, 0, 4'h0, 0, 0,   0, 0, 0, 0, 2'b00, 0, 0, 1, 1);
        add(0, 1, 4'h1, 0, 0,   1, 0, 0, 0, 2'b00, 1, 0, 1, 1); // ADD
        add(0, 0, 4'h1, 0, 0,   0, 1, 1, 0, 2'b00, 1, 0, 1, 1); // CC_WB@2
        add(0, 0, 4'h1, 0, 0,   0, 0, 0, 0, 2'b00, 1, 1, 1, 1); // FINISH@3
        add(0, 1, 4'h3, 0, 0,   0, 0, 0, 0, 2'b00, 0, 0, 1, 1); // Start in FINISH ignored
        add(0, 1, 4'h3, 0, 0,   1, 0, 0, 0, 2'b00, 1, 0, 1, 1); // ST accepted after Done
        add(0, 1, 4'h0, 1, 0,   0, 0, 0, 0, 2'b00, 1, 1, 1, 1); // Start while busy ignored
        add(0, 1, 4'h0, 1, 0,   0, 0, 0, 0, 2'b00, 0, 0, 1, 1); // Start in FINISH ignored
        add(0, 0, 4'h0, 0, 0,   0, 0, 0, 0, 2'b00, 0, 0, 1, 1);
        add(0, 1, 4'h0, 1, 0,   1, 0, 0, 0, 2'b00, 1, 0, 1, 1); // BR, reset in BR_EVAL
        add(0, 0, 4'h0, 1, 0,   0, 0, 0, 0, 2'b00, 1, 0, 1, 1);
        add(1, 0, 4'h0, 1, 0,   0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
        add(1, 0, 4'h0, 1, 0,   0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
        add(0, 0, 4'h0, 1, 0,   0, 0, 0, 0, 2'b00, 0, 0, 0, 0); // no LD_PC after abort
        add(0, 1, 4'h0, 1, 0,   1, 0, 0, 0, 2'b00, 1, 0, 0, 0); // BR, clear vs increment
        add(0, 0, 4'h0, 1, 0,   0, 0, 0, 0, 2'b00, 1, 0, 0, 0);
        add(0, 0, 4'h0, 1, 1,   0, 0, 0, 1, 2'b10, 1, 0, 0, 0);
        add(0, 0, 4'h0, 0, 0,   0, 0, 0, 0, 2'b00, 1, 1, 0, 0);
        add(0, 0, 4'h0, 0, 0,   0, 0, 0, 0, 2'b00, 0, 0, 0, 0);

        foreach (vq[i]) begin
            Reset = vq[i].rst; Start = vq[i].start; Opcode = vq[i].op;
            BEN_In = vq[i].ben; Clear_Stats = vq[i].clr;
            tick();
            check("ld_ben", i, a_ld_ben, vq[i].ld_ben);
            check("ld_cc",  i, a_ld_cc,  vq[i].ld_cc);
            check("ld_reg", i, a_ld_reg, vq[i].ld_reg);
            check("ld_pc",  i, a_ld_pc,  vq[i].ld_pc);
            check("pcmux",  i, a_pcmux,  vq[i].pcmux);
            check("busy",   i, a_busy,   vq[i].busy);
            check("done",   i, a_done,   vq[i].done);
            check("taken",  i, a_taken,  vq[i].taken);
            check("ntaken", i, a_ntaken, vq[i].ntaken);
            check("wrap_taken",  i, b_taken,  vq[i].taken);
            check("wrap_ntaken", i, b_ntaken, vq[i].ntaken);
        end
        Start = 1'b0; BEN_In = 1'b0;

        // Start re-pulsed during an ADD: exactly one Done over a long window
        dones = 0;
        Opcode = 4'h1; Start = 1'b1; tick(); dones += a_done;
        Start = 1'b0; tick(); dones += a_done;
        Start = 1'b1; tick(); dones += a_done;
        Start = 1'b0;
        for (int c = 0; c < 6; c++) begin tick(); dones += a_done; end
        check("single_done", 100, dones, 1);
        check("idle_after", 101, a_busy, 0);

        // 17 taken branches: saturating instance sticks at F, wrapping one reaches 1
        dones = 0;
        for (int n = 1; n <= 17; n++) begin
            Opcode = 4'h0; BEN_In = 1'b1; Start = 1'b1;
            tick();
            Start = 1'b0;
            tick(); tick();
            check("sat_step",  200 + n, a_taken, (n > 15) ? 15 : n);
            check("wrap_step", 200 + n, b_taken, n % 16);
            tick(); dones += a_done;
            tick();
        end
        check("sat_done_cnt", 300, dones, 17);
        check("sat_final",    301, a_taken, 4'hF);
        check("wrap_final",   302, b_taken, 4'h1);

        Clear_Stats = 1'b1; tick(); Clear_Stats = 1'b0;
        check("clr_sat",  400, a_taken, 0);
        check("clr_wrap", 401, b_taken, 0);
        check("clr_busy", 402, a_busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
